// File: rtl/bp_regbank_pkg.sv
// Shared offsets, FSM states and address helper for the BytePipe register bridge.
package bp_regbank_pkg;

    localparam int OFS_BURST   = 0;
    localparam int OFS_FIFO_RD = 1;
    localparam int OFS_FLUSH   = 2;
    localparam int OFS_SEED    = 3;
    localparam int OFS_DEPTH   = 4;
    localparam int OFS_RW0     = 5;
    localparam int CHAN_STRIDE = 16;

    typedef enum logic [1:0] {IDLE, WDATA, RRESP} state_t;

    // Next burst address: offset advances, 15 wraps to the first RW offset, channel is kept.
    function automatic logic [6:0] next_addr(input logic [6:0] a);
        if (a[3:0] == 4'(CHAN_STRIDE - 1))
            next_addr = {a[6:4], 4'(OFS_RW0)};
        else
            next_addr = a + 7'd1;
    endfunction

endpackage

// File: rtl/bp_regbank_fsm.sv
// Command/burst sequencer for bp_regbank. Define BP_REGBANK_AUTOINC_EN to advance the address during bursts.
module bp_regbank_fsm
    import bp_regbank_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_arst_n,
    input  logic       i_cg,
    input  logic       i_cmd_acc,
    input  logic       i_wd_acc,
    input  logic       i_rsp_acc,
    input  logic [7:0] i_data,
    output state_t     o_state,
    output logic [6:0] o_addr,
    output logic [7:0] o_burst
);

    logic       wr;
    logic       bact;
    logic [6:0] addr_nx;

`ifdef BP_REGBANK_AUTOINC_EN
    assign addr_nx = next_addr(o_addr);
`else
    assign addr_nx = o_addr;
`endif

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            o_state <= IDLE;
            o_addr  <= '0;
            o_burst <= '0;
            wr      <= 1'b0;
            bact    <= 1'b0;
        end else if (i_cg) begin
            case (o_state)
                IDLE: if (i_cmd_acc) begin
                    o_addr  <= i_data[6:0];
                    wr      <= i_data[7];
                    bact    <= (o_burst != 8'd0) && (i_data[6:0] != 7'd0);
                    o_state <= i_data[7] ? WDATA : RRESP;
                end
                WDATA: if (i_wd_acc) begin
                    if (o_addr == 7'(OFS_BURST))
                        o_burst <= i_data;
                    else if (bact)
                        o_burst <= o_burst - 8'd1;
                    o_state <= RRESP;
                end
                RRESP: if (i_rsp_acc) begin
                    // write bursts count on the data byte, read bursts on the response
                    if (!bact) begin
                        o_state <= IDLE;
                    end else if (wr) begin
                        if (o_burst != 8'd0) begin
                            o_addr  <= addr_nx;
                            o_state <= WDATA;
                        end else begin
                            o_state <= IDLE;
                        end
                    end else begin
                        o_burst <= o_burst - 8'd1;
                        if (o_burst == 8'd1)
                            o_state <= IDLE;
                        else
                            o_addr <= addr_nx;
                    end
                end
                default: o_state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/bp_regbank.sv
// BytePipe register bridge: per-channel RW regs, WO strobes, RO depth and fifo reads.
// Define BP_REGBANK_AUTOINC_EN for address auto-increment inside bursts.
module bp_regbank
    import bp_regbank_pkg::*;
#(
    parameter int N_CHAN     = 4,
    parameter int N_RW       = 8,
    parameter int RW_W       = 8,
    parameter int FIFO_DEPTH = 10
) (
    input  logic                          i_clk,
    input  logic                          i_arst_n,
    input  logic                          i_cg,
    input  logic [N_CHAN*8-1:0]           i_fifo_data,
    input  logic [N_CHAN-1:0]             i_fifo_empty,
    output logic [N_CHAN-1:0]             o_fifo_pop,
    output logic [N_CHAN-1:0]             o_fifo_flush,
    output logic [7:0]                    o_seed_byte,
    output logic [N_CHAN-1:0]             o_seed_valid,
    output logic [N_CHAN*N_RW*RW_W-1:0]   o_rw,
    output logic [N_CHAN*N_RW-1:0]        o_rw_wr,
    input  logic [7:0]                    i_bp_data,
    input  logic                          i_bp_valid,
    output logic                          o_bp_ready,
    output logic [7:0]                    o_bp_data,
    output logic                          o_bp_valid,
    input  logic                          i_bp_ready
);

    state_t     state;
    logic [6:0] addr;
    logic [7:0] burst;
    logic [2:0] chan;
    logic [3:0] ofs;
    logic       cmd_acc, wd_acc, rsp_acc;
    logic       sel_empty, stall;
    logic [7:0] rd;

    assign chan = addr[6:4];
    assign ofs  = addr[3:0];

    assign o_bp_ready  = i_cg && i_bp_ready && (state != RRESP);
    assign cmd_acc     = o_bp_ready && i_bp_valid && (state == IDLE);
    assign wd_acc      = o_bp_ready && i_bp_valid && (state == WDATA);
    assign rsp_acc     = i_cg && (state == RRESP) && o_bp_valid && i_bp_ready;
    assign o_seed_byte = i_bp_data;

    bp_regbank_fsm u_fsm (
        .i_clk     (i_clk),
        .i_arst_n  (i_arst_n),
        .i_cg      (i_cg),
        .i_cmd_acc (cmd_acc),
        .i_wd_acc  (wd_acc),
        .i_rsp_acc (rsp_acc),
        .i_data    (i_bp_data),
        .o_state   (state),
        .o_addr    (addr),
        .o_burst   (burst)
    );

    for (genvar c = 0; c < N_CHAN; c++) begin : g_chan
        logic hit;
        assign hit             = (chan == 3'(c));
        assign o_fifo_pop[c]   = rsp_acc && hit && (ofs == 4'(OFS_FIFO_RD));
        assign o_fifo_flush[c] = wd_acc && hit && (ofs == 4'(OFS_FLUSH));
        assign o_seed_valid[c] = wd_acc && hit && (ofs == 4'(OFS_SEED));

        for (genvar r = 0; r < N_RW; r++) begin : g_rw
            logic [RW_W-1:0] q;
            assign o_rw_wr[c*N_RW+r] = wd_acc && hit && (ofs == 4'(OFS_RW0 + r));
            assign o_rw[(c*N_RW+r)*RW_W +: RW_W] = q;

            always_ff @(posedge i_clk or negedge i_arst_n) begin
                if (!i_arst_n)
                    q <= '0;
                else if (o_rw_wr[c*N_RW+r])
                    q <= i_bp_data[RW_W-1:0];
            end
        end
    end

    // Out-of-range channels and unmapped offsets fall through to zero.
    always_comb begin
        rd        = '0;
        sel_empty = 1'b0;
        for (int c = 0; c < N_CHAN; c++) begin
            if (chan == 3'(c)) begin
                sel_empty = i_fifo_empty[c];
                if (ofs == 4'(OFS_FIFO_RD)) rd = i_fifo_data[c*8 +: 8];
                if (ofs == 4'(OFS_DEPTH))   rd = 8'(FIFO_DEPTH);
                for (int r = 0; r < N_RW; r++)
                    if (ofs == 4'(OFS_RW0 + r)) rd = 8'(o_rw[(c*N_RW+r)*RW_W +: RW_W]);
            end
        end
        if (addr == 7'(OFS_BURST)) rd = burst;
    end

    assign stall = (state == RRESP) && (ofs == 4'(OFS_FIFO_RD)) && sel_empty;

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            o_bp_valid <= 1'b0;
            o_bp_data  <= '0;
        end else if (i_cg) begin
            if (state != RRESP || rsp_acc) begin
                o_bp_valid <= 1'b0;
            end else if (!o_bp_valid && !stall) begin
                o_bp_valid <= 1'b1;
                o_bp_data  <= rd;
            end
        end
    end

endmodule

// File: tb/tb_bp_regbank.sv
// Self-checking bench for bp_regbank: vector table, directed burst/stall/reset sequences, random vs model.
module tb_bp_regbank;

    localparam int NC = 4;
    localparam int NR = 11;
    localparam int RW = NC*NR*8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cg = 1'b1;
    logic [NC*8-1:0]   fifo_data = '0;
    logic [NC-1:0]     fifo_empty = '1;
    logic [NC-1:0]     fifo_pop, fifo_flush, seed_valid;
    logic [7:0]        seed_byte;
    logic [RW-1:0]     rw;
    logic [NC*NR-1:0]  rw_wr;
    logic [7:0]        din = '0;
    logic              din_valid = 1'b0;
    logic              din_ready;
    logic [7:0]        dout;
    logic              dout_valid;
    logic              dout_ready = 1'b1;

    always #5 clk = ~clk;

    bp_regbank #(.N_CHAN(NC), .N_RW(NR), .RW_W(8), .FIFO_DEPTH(10)) dut (
        .i_clk(clk), .i_arst_n(rst_n), .i_cg(cg),
        .i_fifo_data(fifo_data), .i_fifo_empty(fifo_empty),
        .o_fifo_pop(fifo_pop), .o_fifo_flush(fifo_flush),
        .o_seed_byte(seed_byte), .o_seed_valid(seed_valid),
        .o_rw(rw), .o_rw_wr(rw_wr),
        .i_bp_data(din), .i_bp_valid(din_valid), .o_bp_ready(din_ready),
        .o_bp_data(dout), .o_bp_valid(dout_valid), .i_bp_ready(dout_ready)
    );

    int ncmp = 0;
    int nerr = 0;
    logic [7:0] fq[NC][$];
    int pop_cnt[NC];
    logic [7:0] mrw[NC][NR];
    logic [7:0] mburst;
    logic [NC*NR-1:0] sn_rw_wr;
    logic [NC-1:0] sn_flush, sn_seed;
    logic [7:0] sn_seed_byte;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Behavioural packet fifos: heads are driven each cycle, pops applied after the edge.
    always begin : fifo_model
        logic [NC-1:0] pend;
        for (int c = 0; c < NC; c++) begin
            fifo_empty[c]         = (fq[c].size() == 0);
            fifo_data[c*8 +: 8]   = (fq[c].size() == 0) ? 8'h00 : fq[c][0];
        end
        @(negedge clk);
        pend = fifo_pop;
        for (int c = 0; c < NC; c++) if (pend[c]) pop_cnt[c]++;
        @(posedge clk);
        #1;
        for (int c = 0; c < NC; c++)
            if (pend[c] && fq[c].size() > 0) void'(fq[c].pop_front());
    end

    task automatic send(input logic [7:0] b);
        bit done = 0;
        din = b;
        din_valid = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (din_ready) begin
                sn_rw_wr = rw_wr; sn_flush = fifo_flush; sn_seed = seed_valid; sn_seed_byte = seed_byte;
                @(posedge clk);
                #1;
                done = 1;
            end
        end
        din_valid = 1'b0;
        if (!done) begin
            ncmp++; nerr++;
            $display("FAIL send_timeout: byte %0h not accepted in 100 cycles", b);
        end
    endtask

    task automatic recv(output logic [7:0] b);
        bit done = 0;
        b = 8'hxx;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (dout_valid) begin
                b = dout;
                @(posedge clk);
                #1;
                done = 1;
            end
        end
        if (!done) begin
            ncmp++; nerr++;
            $display("FAIL recv_timeout: no response in 100 cycles");
        end
    endtask

    task automatic do_rd(input logic [6:0] a, input logic [7:0] exp, input string nm);
        logic [7:0] r;
        send({1'b0, a});
        recv(r);
        chk(nm, 512'(r), 512'(exp));
    endtask

    task automatic do_wr(input logic [6:0] a, input logic [7:0] d, input logic [7:0] exp, input string nm);
        logic [7:0] r;
        send({1'b1, a});
        send(d);
        recv(r);
        chk(nm, 512'(r), 512'(exp));
    endtask

    function automatic logic [7:0] mread(input logic [6:0] a);
        int c = int'(a[6:4]);
        int o = int'(a[3:0]);
        if (c >= NC) return 8'h00;
        if (o == 0) return (c == 0) ? mburst : 8'h00;
        if (o == 1) return (fq[c].size() > 0) ? fq[c][0] : 8'h00;
        if (o == 4) return 8'd10;
        if (o >= 5 && o < 5 + NR) return mrw[c][o-5];
        return 8'h00;
    endfunction

    function automatic logic [RW-1:0] mrw_flat();
        logic [RW-1:0] v = '0;
        for (int c = 0; c < NC; c++)
            for (int r = 0; r < NR; r++) v[(c*NR+r)*8 +: 8] = mrw[c][r];
        return v;
    endfunction

    function automatic int pops_total();
        int s = 0;
        for (int c = 0; c < NC; c++) s += pop_cnt[c];
        return s;
    endfunction

    typedef struct {
        logic             wr;
        logic [6:0]       a;
        logic [7:0]       d;
        logic [7:0]       resp;
        logic [NC*NR-1:0] rwwr;
        logic [NC-1:0]    fl;
        logic [NC-1:0]    sd;
    } vec_t;

    vec_t tv[14];

    initial begin : main
        logic [7:0] r;
        logic [RW-1:0] exp_rw;
        int p0;

        for (int c = 0; c < NC; c++) pop_cnt[c] = 0;

        // reset state
        #12;
        chk("rst_valid", 512'(dout_valid), 512'(0));
        chk("rst_rw", 512'(rw), 512'(0));
        chk("rst_strobes", 512'({rw_wr, fifo_pop, fifo_flush, seed_valid}), 512'(0));
        chk("rst_ready", 512'(din_ready), 512'(1));
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        tv[0]  = '{1'b1, 7'h05, 8'h2A, 8'h2A, 44'h1 << 0,  4'b0000, 4'b0000};
        tv[1]  = '{1'b0, 7'h05, 8'h00, 8'h2A, 44'h0,       4'b0000, 4'b0000};
        tv[2]  = '{1'b0, 7'h04, 8'h00, 8'h0A, 44'h0,       4'b0000, 4'b0000};
        tv[3]  = '{1'b0, 7'h34, 8'h00, 8'h0A, 44'h0,       4'b0000, 4'b0000};
        tv[4]  = '{1'b1, 7'h3C, 8'h55, 8'h55, 44'h1 << 40, 4'b0000, 4'b0000};
        tv[5]  = '{1'b1, 7'h3D, 8'h66, 8'h66, 44'h1 << 41, 4'b0000, 4'b0000};
        tv[6]  = '{1'b0, 7'h7F, 8'h00, 8'h00, 44'h0,       4'b0000, 4'b0000};
        tv[7]  = '{1'b1, 7'h75, 8'hFF, 8'h00, 44'h0,       4'b0000, 4'b0000};
        tv[8]  = '{1'b1, 7'h12, 8'h00, 8'h00, 44'h0,       4'b0010, 4'b0000};
        tv[9]  = '{1'b1, 7'h23, 8'h5A, 8'h00, 44'h0,       4'b0000, 4'b0100};
        tv[10] = '{1'b1, 7'h04, 8'h99, 8'h0A, 44'h0,       4'b0000, 4'b0000};
        tv[11] = '{1'b0, 7'h10, 8'h00, 8'h00, 44'h0,       4'b0000, 4'b0000};
        tv[12] = '{1'b1, 7'h4C, 8'h1F, 8'h00, 44'h0,       4'b0000, 4'b0000};
        tv[13] = '{1'b1, 7'h16, 8'hC3, 8'hC3, 44'h1 << 12, 4'b0000, 4'b0000};

        for (int i = 0; i < 14; i++) begin
            if (tv[i].wr) begin
                do_wr(tv[i].a, tv[i].d, tv[i].resp, $sformatf("vec%0d_resp", i));
                chk($sformatf("vec%0d_strobes", i), 512'({sn_rw_wr, sn_flush, sn_seed}),
                    512'({tv[i].rwwr, tv[i].fl, tv[i].sd}));
                if (tv[i].sd != 0) chk($sformatf("vec%0d_seed_byte", i), 512'(sn_seed_byte), 512'(tv[i].d));
            end else begin
                do_rd(tv[i].a, tv[i].resp, $sformatf("vec%0d_resp", i));
            end
        end
        exp_rw = '0;
        exp_rw[0*8 +: 8]  = 8'h2A;
        exp_rw[12*8 +: 8] = 8'hC3;
        exp_rw[40*8 +: 8] = 8'h55;
        exp_rw[41*8 +: 8] = 8'h66;
        chk("table_rw", 512'(rw), 512'(exp_rw));
        chk("table_no_pops", 512'(pops_total()), 512'(0));

        // empty-fifo stall, then a single pop
        p0 = pop_cnt[0];
        send(8'h01);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("stall_cyc%0d", i), 512'({dout_valid, din_ready}), 512'(0));
        end
        fq[0].push_back(8'h77);
        recv(r);
        chk("stall_data", 512'(r), 512'(8'h77));
        @(posedge clk); #2;
        chk("stall_one_pop", 512'(pop_cnt[0] - p0), 512'(1));

        // burst of 3 reads on chan1 fifo
        fq[1].push_back(8'h11); fq[1].push_back(8'h22); fq[1].push_back(8'h33);
        repeat (2) @(posedge clk); #1;
        p0 = pop_cnt[1];
        do_wr(7'h00, 8'h03, 8'h03, "burst_load");
        send(8'h11);
`ifdef BP_REGBANK_AUTOINC_EN
        recv(r); chk("bursrd0", 512'(r), 512'(8'h11));
        recv(r); chk("bursrd1", 512'(r), 512'(8'h00));
        recv(r); chk("bursrd2", 512'(r), 512'(8'h00));
        #2; chk("bursrd_pops", 512'(pop_cnt[1] - p0), 512'(1));
        fq[1].delete();
`else
        recv(r); chk("bursrd0", 512'(r), 512'(8'h11));
        recv(r); chk("bursrd1", 512'(r), 512'(8'h22));
        recv(r); chk("bursrd2", 512'(r), 512'(8'h33));
        #2; chk("bursrd_pops", 512'(pop_cnt[1] - p0), 512'(3));
`endif
        @(negedge clk);
        chk("bursrd_idle", 512'({din_ready, dout_valid}), 512'(2'b10));
        do_rd(7'h00, 8'h00, "bursrd_burst_zero");

        // burst of 3 writes starting at chan1 offset 14
        do_wr(7'h00, 8'h03, 8'h03, "burstwr_load");
        send(8'h9E);
        for (int i = 1; i <= 3; i++) begin
            send(8'(i));
            recv(r);
            chk($sformatf("burstwr_echo%0d", i), 512'(r), 512'(i));
        end
        do_rd(7'h00, 8'h00, "burstwr_burst_zero");
`ifdef BP_REGBANK_AUTOINC_EN
        do_rd(7'h1E, 8'h01, "burstwr_o14");
        do_rd(7'h1F, 8'h02, "burstwr_o15");
        do_rd(7'h15, 8'h03, "burstwr_o5_wrap");
`else
        do_rd(7'h1E, 8'h03, "burstwr_o14");
        do_rd(7'h1F, 8'h00, "burstwr_o15");
        do_rd(7'h15, 8'h00, "burstwr_o5");
`endif

        // async reset during a stalled burst read
        do_wr(7'h00, 8'h05, 8'h05, "rst_burst_load");
        send(8'h04);
        dout_ready = 1'b0;
        begin
            bit seen = 0;
            for (int i = 0; i < 10 && !seen; i++) begin
                @(negedge clk);
                seen = dout_valid;
            end
            chk("rst_pre_valid", 512'(seen), 512'(1));
        end
        #1 rst_n = 1'b0;
        #1 chk("rst_async_valid", 512'(dout_valid), 512'(0));
        chk("rst_async_rw", 512'(rw), 512'(0));
        @(negedge clk); rst_n = 1'b1; dout_ready = 1'b1;
        @(negedge clk);
        chk("rst_after_ready", 512'(din_ready), 512'(1));
        @(posedge clk); #1;
        do_rd(7'h00, 8'h00, "rst_after_burst");
        do_rd(7'h05, 8'h00, "rst_after_reg");
        do_rd(7'h04, 8'h0A, "rst_after_depth");

        // randomized single transactions against the model
        for (int c = 0; c < NC; c++) for (int r2 = 0; r2 < NR; r2++) mrw[c][r2] = 8'h00;
        mburst = 8'h00;
        for (int n = 0; n < 60; n++) begin
            logic [6:0] a;
            logic wr;
            logic [7:0] d, e;
            logic [NC*NR-1:0] erw;
            logic [NC-1:0] efl, esd;
            int c, o;
            #2;
            a = 7'($urandom_range(0, 127));
            wr = 1'($urandom_range(0, 1));
            d = 8'($urandom);
            c = int'(a[6:4]);
            o = int'(a[3:0]);
            if (wr && (a == 7'h00 || o == 1)) wr = 1'b0;
            if (wr) begin
                erw = '0; efl = '0; esd = '0;
                if (c < NC) begin
                    if (o >= 5 && o < 5 + NR) begin mrw[c][o-5] = d; erw[c*NR + o - 5] = 1'b1; end
                    if (o == 2) efl[c] = 1'b1;
                    if (o == 3) esd[c] = 1'b1;
                end
                e = mread(a);
                do_wr(a, d, e, $sformatf("rnd%0d_wr_%0h", n, a));
                chk($sformatf("rnd%0d_strobes", n), 512'({sn_rw_wr, sn_flush, sn_seed}), 512'({erw, efl, esd}));
                chk($sformatf("rnd%0d_rw", n), 512'(rw), 512'(mrw_flat()));
            end else begin
                if (c < NC && o == 1 && fq[c].size() == 0) fq[c].push_back(8'($urandom));
                e = mread(a);
                p0 = pops_total();
                do_rd(a, e, $sformatf("rnd%0d_rd_%0h", n, a));
                chk($sformatf("rnd%0d_pops", n), 512'(pops_total() - p0), 512'((c < NC && o == 1) ? 1 : 0));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
